// File: rtl/fp_row_block_quantizer.sv
// fp_row_block_quantizer
//
// Quantizes one row of MAT_SIZE single-precision floats into signed INT_W
// block-floating-point integers. All lanes share one exponent: the raw
// exponent of the row's absmax, which arrives alongside the row. The row is
// processed LANES_PER_CYCLE lanes per cycle.
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_valid_i    row and max exponent valid
//   in_ready_o    block can accept a row (IDLE only)
//   data_i        input row, lane i at [(i+1)*FP_DATA_W-1 -: FP_DATA_W]
//   max_exp_i     raw (biased) exponent of the row absmax
//   out_valid_o   quantized row valid (DONE)
//   out_ready_i   consumer accepts the row
//   qdata_o       two's-complement lanes, lane i at [(i+1)*INT_W-1 -: INT_W]
//   shared_exp_o  captured max_exp_i
//   busy_o        high in BUSY or DONE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a row; a valid row is captured with its max exponent
// BUSY  | one beat of LANES_PER_CYCLE lanes quantized per cycle
// DONE  | row complete; outputs frozen until the consumer accepts
module fp_row_block_quantizer #(
   parameter int MAT_SIZE        = 16,
   parameter int LANES_PER_CYCLE = 4,
   parameter int FP_DATA_W       = 32,
   parameter int FP_EXP_W        = 8,
   parameter int FP_MANT_W       = 23,
   parameter int INT_W           = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [FP_DATA_W*MAT_SIZE-1:0] data_i,
   input  logic [FP_EXP_W-1:0]           max_exp_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [INT_W*MAT_SIZE-1:0]     qdata_o,
   output logic [FP_EXP_W-1:0]           shared_exp_o,
   output logic                          busy_o
);

   localparam int BEATS  = MAT_SIZE / LANES_PER_CYCLE;
   localparam int MW     = INT_W - 1;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [FP_EXP_W:0]   MW_SH     = (FP_EXP_W + 1)'(MW);
   localparam logic [FP_EXP_W:0]   ONE_EXP   = (FP_EXP_W + 1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                        state, state_nxt;
   logic [BEAT_W-1:0]             beat;
   logic [FP_DATA_W*MAT_SIZE-1:0] row_q;
   logic [FP_EXP_W-1:0]           emax_q;
   logic [INT_W*MAT_SIZE-1:0]     qdata_q;

   // Aligns one lane to the shared exponent. Only the top MW bits of the
   // significand survive; shifting right truncates toward zero. Inf/NaN and
   // lanes larger than the claimed max saturate to the largest magnitude, so
   // -2^MW can never appear.
   function automatic logic [INT_W-1:0] quant_lane(
      input logic [FP_DATA_W-1:0] f,
      input logic [FP_EXP_W-1:0]  emax
   );
      logic                 s;
      logic [FP_EXP_W-1:0]  e;
      logic [FP_MANT_W-1:0] m;
      logic [FP_EXP_W:0]    e_eff;
      logic [FP_EXP_W:0]    emax_eff;
      logic [FP_EXP_W:0]    sh;
      logic [FP_MANT_W:0]   w;
      logic [MW-1:0]        top;
      logic [MW-1:0]        mag;
      s        = f[FP_DATA_W-1];
      e        = f[FP_MANT_W +: FP_EXP_W];
      m        = f[FP_MANT_W-1:0];
      e_eff    = (e == '0) ? ONE_EXP : {1'b0, e};
      emax_eff = (emax == '0) ? ONE_EXP : {1'b0, emax};
      w        = {(e != '0), m};
      top      = w[FP_MANT_W -: MW];
      sh       = emax_eff - e_eff;
      if ((e == '1) || ({1'b0, e} > emax_eff)) begin
         mag = '1;
      end else if (sh >= MW_SH) begin
         mag = '0;
      end else begin
         mag = top >> sh;
      end
      quant_lane = s ? -{1'b0, mag} : {1'b0, mag};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid_i) state_nxt = BUSY;
         BUSY:    if (beat == LAST_BEAT) state_nxt = DONE;
         DONE:    if (out_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      case (state)
         IDLE: in_ready_o = 1'b1;
         BUSY: busy_o = 1'b1;
         DONE: begin
            out_valid_o = 1'b1;
            busy_o      = 1'b1;
         end
         default: in_ready_o = 1'b0;
      endcase
   end

   // qdata is not cleared on capture: lanes keep the previous row's codes
   // until their beat overwrites them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat    <= '0;
         row_q   <= '0;
         emax_q  <= '0;
         qdata_q <= '0;
      end else if (state == IDLE) begin
         if (in_valid_i) begin
            row_q  <= data_i;
            emax_q <= max_exp_i;
            beat   <= '0;
         end
      end else if (state == BUSY) begin
         for (int k = 0; k < LANES_PER_CYCLE; k++) begin
            qdata_q[(int'(beat) * LANES_PER_CYCLE + k) * INT_W +: INT_W] <=
               quant_lane(row_q[(int'(beat) * LANES_PER_CYCLE + k) * FP_DATA_W +: FP_DATA_W],
                          emax_q);
         end
         beat <= beat + 1'b1;
      end
   end

   assign qdata_o      = qdata_q;
   assign shared_exp_o = emax_q;

endmodule
